// File: rtl/noise_table_loader.sv
// Sequencer that streams a CDF threshold table into the 128-level noise generator,
// waits for it to arm, then gates its enable from a run request.
module noise_table_loader #(
  parameter int N_ENTRIES = 128,
  parameter int DATA_W    = 64,
  parameter int ADDR_W    = 8,
  parameter int PAD_BEATS = 2,
  parameter int TIMEOUT   = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic              run_req,
  output logic [DATA_W-1:0] gen_mem_data,
  output logic [ADDR_W-1:0] gen_location,
  output logic              gen_load_mem,
  input  logic              gen_done_wait,
  output logic              gen_en,
  output logic              busy,
  output logic              loaded,
  output logic              err_nonmono,
  output logic              err_timeout,
  output logic [ADDR_W-1:0] entry_count
);

  localparam int TIMER_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int PAD_W   = $clog2(PAD_BEATS + 1);

  typedef enum logic [2:0] {IDLE, LOAD, PAD, WAIT_DONE, RUN, ERROR} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   idx;
  logic [DATA_W-1:0]   prev;
  logic [TIMER_W-1:0]  timer;
  logic [PAD_W-1:0]    pad_cnt;
  logic                beat;
  logic                restart;

  assign cfg_ready = (state == LOAD);
  assign busy      = (state == LOAD) || (state == PAD) || (state == WAIT_DONE);
  assign beat      = cfg_valid && cfg_ready;
  // start is only honoured where no table transfer is in flight
  assign restart   = start && ((state == IDLE) || (state == RUN) || (state == ERROR));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      prev         <= '0;
      timer        <= '0;
      pad_cnt      <= '0;
      gen_mem_data <= '0;
      gen_location <= '0;
      gen_load_mem <= 1'b0;
      gen_en       <= 1'b0;
      loaded       <= 1'b0;
      err_nonmono  <= 1'b0;
      err_timeout  <= 1'b0;
      entry_count  <= '0;
    end else begin
      gen_load_mem <= 1'b0;
      if (restart) begin
        state       <= LOAD;
        idx         <= '0;
        entry_count <= '0;
        loaded      <= 1'b0;
        gen_en      <= 1'b0;
        err_nonmono <= 1'b0;
        err_timeout <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            gen_en <= 1'b0;
          end
          LOAD: begin
            if (beat) begin
              gen_mem_data <= cfg_data;
              gen_location <= idx;
              gen_load_mem <= 1'b1;
              entry_count  <= entry_count + ADDR_W'(1);
              prev         <= cfg_data;
              if ((idx != '0) && (cfg_data < prev)) err_nonmono <= 1'b1;
              if (idx == ADDR_W'(N_ENTRIES - 1)) begin
                state   <= PAD;
                pad_cnt <= '0;
              end else begin
                idx <= idx + ADDR_W'(1);
              end
            end
          end
          PAD: begin
            // the generator arms only after extra load_mem pulses past the last entry
            if (pad_cnt == PAD_W'(PAD_BEATS)) begin
              state <= WAIT_DONE;
              timer <= '0;
            end else begin
              gen_load_mem <= 1'b1;
              pad_cnt      <= pad_cnt + PAD_W'(1);
            end
          end
          WAIT_DONE: begin
            if (gen_done_wait) begin
              state  <= RUN;
              loaded <= 1'b1;
            end else if (timer == TIMER_W'(TIMEOUT - 1)) begin
              state       <= ERROR;
              err_timeout <= 1'b1;
            end else begin
              timer <= timer + TIMER_W'(1);
            end
          end
          RUN: begin
            gen_en <= run_req;
          end
          ERROR: begin
            gen_en <= 1'b0;
            loaded <= 1'b0;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
